// File: rtl/mor1kx_tcm_arbiter_pkg.sv
// Shared types and constants for the instruction TCM arbiter.
// Holds the last-grant encoding and the address range check.
package mor1kx_tcm_arbiter_pkg;

  localparam int unsigned TCM_DATA_WIDTH = 32;
  localparam int unsigned TCM_ADR_WIDTH  = 32;
  localparam int unsigned TCM_SEL_WIDTH  = 4;
  localparam int unsigned STARVE_CNT_W   = 4;

  typedef enum logic [2:0] {
    GNT_NONE    = 3'd0,
    GNT_CPU_RD  = 3'd1,
    GNT_WB_RD   = 3'd2,
    GNT_WB_WR   = 3'd3,
    GNT_CPU_ERR = 3'd4,
    GNT_WB_ERR  = 3'd5
  } grant_e;

  // Any address bit at or above the TCM window makes the access out of range
  function automatic logic adr_out_of_range(input logic [TCM_ADR_WIDTH-1:0] adr,
                                            input int unsigned aw);
    return (adr >> aw) != TCM_ADR_WIDTH'(0);
  endfunction

endpackage

// File: rtl/mor1kx_tcm_arb_starve.sv
// Saturating count of Wishbone arbitration losses; raises forced priority
// for Wishbone once the count reaches STARVE_MAX.
module mor1kx_tcm_arb_starve
  import mor1kx_tcm_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_req,
  input  logic                    wb_gnt,
  output logic                    force_wb_c,
  output logic [STARVE_CNT_W-1:0] cnt
);

  localparam logic [STARVE_CNT_W-1:0] CNT_MAX = STARVE_CNT_W'(STARVE_MAX);

  // A pending WB request that is not granted can only have lost to the CPU
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!wb_req || wb_gnt) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + STARVE_CNT_W'(1);
    end
  end

  assign force_wb_c = (cnt == CNT_MAX);

endmodule

// File: rtl/mor1kx_tcm_arbiter.sv
// Arbitrates a single-port instruction TCM between CPU fetch and a Wishbone
// slave; CPU has priority, Wishbone is forced through after bounded starvation.
module mor1kx_tcm_arbiter
  import mor1kx_tcm_arbiter_pkg::*;
#(
  parameter int unsigned TCM_AW        = 15,
  parameter int unsigned DATA_WIDTH    = TCM_DATA_WIDTH,
  parameter int unsigned WB_STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [31:0]           cpu_adr_i,
  input  logic                  cpu_req_i,
  output logic [DATA_WIDTH-1:0] cpu_dat_o,
  output logic                  cpu_ack_o,
  output logic                  cpu_err_o,

  input  logic [31:0]           wbs_adr_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [DATA_WIDTH-1:0] wbs_dat_i,
  output logic [DATA_WIDTH-1:0] wbs_dat_o,
  output logic                  wbs_ack_o,
  output logic                  wbs_err_o,
  output logic                  wbs_rty_o,

  output logic [TCM_AW-3:0]     mem_addr_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_din_o,
  input  logic [DATA_WIDTH-1:0] mem_dout_i
);

  grant_e                  last_grant;
  grant_e                  grant_nxt;
  logic                    cpu_req;
  logic                    wb_req;
  logic                    cpu_gnt;
  logic                    wb_gnt;
  logic                    cpu_oor;
  logic                    wb_oor;
  logic                    force_wb;
  logic [STARVE_CNT_W-1:0] starve_cnt;
  logic                    unused_adr_bits;

  // Requests are masked during reset so nothing reaches the RAM or the counter
  assign cpu_req = cpu_req_i & ~rst;
  // The classic-cycle strobe is still stale in the cycle it is answered
  assign wb_req  = wbs_cyc_i & wbs_stb_i & ~(wbs_ack_o | wbs_err_o) & ~rst;

  assign wb_gnt  = wb_req & (force_wb | ~cpu_req);
  assign cpu_gnt = cpu_req & ~wb_gnt;

  assign cpu_oor = adr_out_of_range(cpu_adr_i, TCM_AW);
  assign wb_oor  = adr_out_of_range(wbs_adr_i, TCM_AW);

  assign unused_adr_bits = ^{cpu_adr_i[1:0], wbs_adr_i[1:0], starve_cnt};

  mor1kx_tcm_arb_starve #(
    .STARVE_MAX (WB_STARVE_MAX)
  ) u_starve (
    .clk        (clk),
    .rst        (rst),
    .wb_req     (wb_req),
    .wb_gnt     (wb_gnt),
    .force_wb_c (force_wb),
    .cnt        (starve_cnt)
  );

  // Grant decode: the RAM strobe must be issued in the grant cycle itself
  always_comb begin
    grant_nxt  = GNT_NONE;
    mem_en_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_be_o   = 4'h0;
    mem_addr_o = '0;
    mem_din_o  = '0;
    if (cpu_gnt) begin
      if (cpu_oor) begin
        grant_nxt = GNT_CPU_ERR;
      end else begin
        grant_nxt  = GNT_CPU_RD;
        mem_en_o   = 1'b1;
        mem_be_o   = 4'hF;
        mem_addr_o = cpu_adr_i[TCM_AW-1:2];
      end
    end else if (wb_gnt) begin
      if (wb_oor) begin
        grant_nxt = GNT_WB_ERR;
      end else begin
        mem_en_o   = 1'b1;
        mem_addr_o = wbs_adr_i[TCM_AW-1:2];
        if (wbs_we_i) begin
          grant_nxt = GNT_WB_WR;
          mem_we_o  = 1'b1;
          mem_be_o  = wbs_sel_i;
          mem_din_o = wbs_dat_i;
        end else begin
          grant_nxt = GNT_WB_RD;
          mem_be_o  = 4'hF;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GNT_NONE;
    end else begin
      last_grant <= grant_nxt;
    end
  end

  // Responses decode the registered grant; reset suppresses an in-flight ack
  assign cpu_ack_o = (last_grant == GNT_CPU_RD) & ~rst;
  assign cpu_err_o = (last_grant == GNT_CPU_ERR) & ~rst;
  assign wbs_ack_o = ((last_grant == GNT_WB_RD) | (last_grant == GNT_WB_WR)) & ~rst;
  assign wbs_err_o = (last_grant == GNT_WB_ERR) & ~rst;
  assign wbs_rty_o = 1'b0;

  assign cpu_dat_o = cpu_ack_o ? mem_dout_i : '0;
  assign wbs_dat_o = ((last_grant == GNT_WB_RD) & ~rst) ? mem_dout_i : '0;

endmodule
